// File: rtl/waveform_loader.sv
// Host-side command parser for the waveform playback path: loads RAM
// contents and the playback window from a big-endian byte stream.
module waveform_loader #(
   parameter int ADDRESS_DEPTH = 13
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic [7:0]               in_data,
   input  logic                     in_valid,
   output logic                     in_ready,
   output logic [ADDRESS_DEPTH-1:0] ram_write_address,
   output logic [7:0]               ram_data,
   output logic                     ram_write_enable,
   output logic [31:0]              start_sample,
   output logic [31:0]              end_sample,
   output logic                     sync_read_address,
   output logic                     busy,
   output logic                     error
);

   localparam logic [7:0] OP_SET_START = 8'h01;
   localparam logic [7:0] OP_SET_END   = 8'h02;
   localparam logic [7:0] OP_WRITE     = 8'h03;
   localparam logic [7:0] OP_RESYNC    = 8'h04;

   typedef enum logic [2:0] {
      IDLE,
      START_B,
      END_B,
      ADDR,
      COUNT,
      DATA
   } state_t;

   state_t                   state;
   logic [1:0]               byte_cnt;
   logic [23:0]              shadow;
   logic [ADDRESS_DEPTH-1:0] wr_addr;
   logic [15:0]              remaining;

   logic        accept;
   logic [31:0] field32;
   logic [15:0] field16;

   assign in_ready = ~reset;
   assign accept   = in_valid & in_ready;
   assign busy     = (state != IDLE);

   // Shadow plus the incoming byte is the fully assembled field
   assign field32 = {shadow, in_data};
   assign field16 = {shadow[7:0], in_data};

   always_ff @(posedge clock) begin
      if (reset) begin
         state             <= IDLE;
         byte_cnt          <= 2'd0;
         shadow            <= 24'd0;
         wr_addr           <= '0;
         remaining         <= 16'd0;
         ram_write_address <= '0;
         ram_data          <= 8'd0;
         ram_write_enable  <= 1'b0;
         start_sample      <= 32'd0;
         end_sample        <= 32'd0;
         sync_read_address <= 1'b0;
         error             <= 1'b0;
      end else begin
         ram_write_enable  <= 1'b0;
         sync_read_address <= 1'b0;
         if (accept) begin
            unique case (state)
               IDLE: begin
                  byte_cnt <= 2'd0;
                  unique case (in_data)
                     OP_SET_START: state <= START_B;
                     OP_SET_END:   state <= END_B;
                     OP_WRITE:     state <= ADDR;
                     OP_RESYNC:    sync_read_address <= 1'b1;
                     default:      error <= 1'b1;
                  endcase
               end
               START_B, END_B: begin
                  shadow   <= field32[23:0];
                  byte_cnt <= byte_cnt + 2'd1;
                  if (byte_cnt == 2'd3) begin
                     if (state == START_B)
                        start_sample <= field32;
                     else
                        end_sample <= field32;
                     state <= IDLE;
                  end
               end
               ADDR: begin
                  shadow   <= field32[23:0];
                  byte_cnt <= byte_cnt + 2'd1;
                  if (byte_cnt[0]) begin
                     wr_addr  <= field16[ADDRESS_DEPTH-1:0];
                     byte_cnt <= 2'd0;
                     state    <= COUNT;
                  end
               end
               COUNT: begin
                  shadow   <= field32[23:0];
                  byte_cnt <= byte_cnt + 2'd1;
                  if (byte_cnt[0]) begin
                     remaining <= field16;
                     byte_cnt  <= 2'd0;
                     state     <= (field16 == 16'd0) ? IDLE : DATA;
                  end
               end
               DATA: begin
                  ram_write_enable  <= 1'b1;
                  ram_data          <= in_data;
                  ram_write_address <= wr_addr;
                  wr_addr           <= wr_addr + ADDRESS_DEPTH'(1);
                  remaining         <= remaining - 16'd1;
                  if (remaining == 16'd1)
                     state <= IDLE;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_waveform_loader.sv
// Bench for waveform_loader: directed sequences, a vector table and a
// randomized command stream checked against a command-level model.
`timescale 1ns/1ps
module tb_waveform_loader;

   localparam int AD = 13;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic [7:0]    in_data = 8'd0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [AD-1:0] ram_write_address;
   logic [7:0]    ram_data;
   logic          ram_write_enable;
   logic [31:0]   start_sample;
   logic [31:0]   end_sample;
   logic          sync_read_address;
   logic          busy;
   logic          error;

   waveform_loader #(.ADDRESS_DEPTH(AD)) dut (
      .clock(clock),
      .reset(reset),
      .in_data(in_data),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .ram_write_address(ram_write_address),
      .ram_data(ram_data),
      .ram_write_enable(ram_write_enable),
      .start_sample(start_sample),
      .end_sample(end_sample),
      .sync_read_address(sync_read_address),
      .busy(busy),
      .error(error)
   );

   always #5 clock = ~clock;

   int tests = 0;
   int fails = 0;
   int sync_seen = 0;
   logic [AD-1:0] q_addr[$];
   logic [7:0]    q_data[$];
   logic [AD-1:0] mon_a;
   logic [7:0]    mon_d;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Every write strobe must match the next expected RAM write, in order
   always @(negedge clock) begin
      if (!reset) begin
         if (sync_read_address) sync_seen++;
         if (ram_write_enable) begin
            tests++;
            if (q_addr.size() == 0) begin
               fails++;
               $display("FAIL unexpected_write: got addr %h data %h expected none",
                        ram_write_address, ram_data);
            end else begin
               mon_a = q_addr.pop_front();
               mon_d = q_data.pop_front();
               if (ram_write_address !== mon_a || ram_data !== mon_d) begin
                  fails++;
                  $display("FAIL ram_write: got %h/%h expected %h/%h",
                           ram_write_address, ram_data, mon_a, mon_d);
               end
            end
         end
      end
   end

   task automatic send(input logic [7:0] b);
      in_data  = b;
      in_valid = 1'b1;
      @(posedge clock);
      #1;
      in_valid = 1'b0;
      in_data  = 8'($urandom);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic send_g(input logic [7:0] b);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      send(b);
   endtask

   task automatic expw(input int a, input logic [7:0] d);
      q_addr.push_back(AD'(a % (1 << AD)));
      q_data.push_back(d);
   endtask

   task automatic do_reset();
      reset    = 1'b1;
      in_valid = 1'b0;
      idle(2);
      reset = 1'b0;
      q_addr.delete();
      q_data.delete();
   endtask

   typedef struct {
      logic [7:0]  op;
      logic [31:0] val;
      logic [31:0] es;
      logic [31:0] ee;
      logic        eerr;
   } vec_t;

   vec_t        tbl[7];
   logic [31:0] exp_start, exp_end, v;
   logic [15:0] a16;
   logic [7:0]  op, d;
   logic        exp_err;
   int          exp_sync, k, n;

   initial begin
      #10_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      in_valid = 1'b1;
      in_data  = 8'h03;
      idle(2);
      @(negedge clock);
      check("rst_in_ready", in_ready, 0);
      check("rst_we", ram_write_enable, 0);
      check("rst_addr", ram_write_address, 0);
      check("rst_data", ram_data, 0);
      check("rst_start", start_sample, 0);
      check("rst_end", end_sample, 0);
      check("rst_sync", sync_read_address, 0);
      check("rst_busy", busy, 0);
      check("rst_error", error, 0);
      in_valid = 1'b0;
      do_reset();
      @(negedge clock);
      check("in_ready_run", in_ready, 1);

      // SET_START, field only visible after final byte
      send(8'h01);
      @(negedge clock);
      check("ss_busy1", busy, 1);
      check("ss_start1", start_sample, 0);
      send(8'h00);
      send(8'h00);
      send(8'h01);
      @(negedge clock);
      check("ss_busy4", busy, 1);
      check("ss_start4", start_sample, 0);
      send(8'h00);
      @(negedge clock);
      check("ss_start", start_sample, 32'h100);
      check("ss_busy_end", busy, 0);

      // WRITE three bytes, back-to-back strobes
      expw(12'h010, 8'hAA);
      expw(12'h011, 8'hBB);
      expw(12'h012, 8'hCC);
      send(8'h03); send(8'h00); send(8'h10); send(8'h00); send(8'h03);
      @(negedge clock);
      check("wr_pre_we", ram_write_enable, 0);
      send(8'hAA);
      @(negedge clock);
      check("wr0_we", ram_write_enable, 1);
      check("wr0_addr", ram_write_address, 13'h010);
      send(8'hBB);
      @(negedge clock);
      check("wr1_we", ram_write_enable, 1);
      check("wr1_data", ram_data, 8'hBB);
      send(8'hCC);
      @(negedge clock);
      check("wr2_we", ram_write_enable, 1);
      check("wr2_addr", ram_write_address, 13'h012);
      check("wr_busy", busy, 0);
      @(negedge clock);
      check("wr_we_off", ram_write_enable, 0);

      // Address wrap and zero count
      expw(13'h1FFF, 8'h11);
      expw(13'h0000, 8'h22);
      send(8'h03); send(8'h1F); send(8'hFF); send(8'h00); send(8'h02);
      send(8'h11);
      @(negedge clock);
      check("wrap0_addr", ram_write_address, 13'h1FFF);
      send(8'h22);
      @(negedge clock);
      check("wrap1_addr", ram_write_address, 13'h0000);
      check("wrap1_data", ram_data, 8'h22);
      send(8'h03); send(8'h00); send(8'h00); send(8'h00); send(8'h00);
      @(negedge clock);
      check("zero_busy", busy, 0);
      idle(3);
      check("q_empty_dir", q_addr.size(), 0);

      // Resync pulse, unknown opcode, gaps
      send(8'h04);
      @(negedge clock);
      check("sync_pulse", sync_read_address, 1);
      @(negedge clock);
      check("sync_width", sync_read_address, 0);
      send(8'h7E);
      @(negedge clock);
      check("err_set", error, 1);
      check("err_idle", busy, 0);
      send(8'h02); idle(3);
      send(8'h00); idle(3);
      send(8'h00); idle(3);
      check("gap_end_hold", end_sample, 0);
      check("gap_busy", busy, 1);
      send(8'h20); idle(3);
      send(8'h00);
      @(negedge clock);
      check("gap_end", end_sample, 32'h2000);
      check("err_sticky", error, 1);

      // Reset mid-command
      send(8'h02); send(8'h00); send(8'h00);
      reset = 1'b1;
      idle(1);
      reset = 1'b0;
      @(negedge clock);
      check("mid_end", end_sample, 0);
      check("mid_busy", busy, 0);
      check("mid_error", error, 0);
      send(8'h04);
      @(negedge clock);
      check("mid_sync", sync_read_address, 1);

      // Table-driven window/opcode vectors
      do_reset();
      tbl[0] = '{8'h01, 32'hDEADBEEF, 32'hDEADBEEF, 32'h0, 1'b0};
      tbl[1] = '{8'h02, 32'h12345678, 32'hDEADBEEF, 32'h12345678, 1'b0};
      tbl[2] = '{8'h01, 32'h00000000, 32'h0, 32'h12345678, 1'b0};
      tbl[3] = '{8'h02, 32'hFFFFFFFF, 32'h0, 32'hFFFFFFFF, 1'b0};
      tbl[4] = '{8'h00, 32'h0, 32'h0, 32'hFFFFFFFF, 1'b1};
      tbl[5] = '{8'h01, 32'h80000001, 32'h80000001, 32'hFFFFFFFF, 1'b1};
      tbl[6] = '{8'hFF, 32'h0, 32'h80000001, 32'hFFFFFFFF, 1'b1};
      for (int i = 0; i < 7; i++) begin
         send(tbl[i].op);
         if (tbl[i].op == 8'h01 || tbl[i].op == 8'h02)
            for (int b = 3; b >= 0; b--) send(tbl[i].val[8*b +: 8]);
         @(negedge clock);
         check($sformatf("tbl%0d_start", i), start_sample, tbl[i].es);
         check($sformatf("tbl%0d_end", i), end_sample, tbl[i].ee);
         check($sformatf("tbl%0d_err", i), error, tbl[i].eerr);
      end

      // Randomized command stream against command-level model
      do_reset();
      sync_seen = 0;
      exp_start = 0;
      exp_end   = 0;
      exp_err   = 0;
      exp_sync  = 0;
      for (int c = 0; c < 150; c++) begin
         k = $urandom_range(0, 9);
         if (k <= 2) begin
            v  = $urandom;
            op = (k == 0) ? 8'h01 : 8'h02;
            send_g(op);
            for (int b = 3; b >= 0; b--) send_g(v[8*b +: 8]);
            if (op == 8'h01) exp_start = v;
            else exp_end = v;
            @(negedge clock);
            check("rnd_start", start_sample, exp_start);
            check("rnd_end", end_sample, exp_end);
         end else if (k <= 6) begin
            a16 = 16'($urandom);
            if (k == 6) a16 = {3'($urandom), 13'h1FFC};
            n = $urandom_range(0, 12);
            send_g(8'h03);
            send_g(a16[15:8]);
            send_g(a16[7:0]);
            send_g(8'(n >> 8));
            send_g(8'(n));
            for (int i = 0; i < n; i++) begin
               d = 8'($urandom);
               expw(int'(a16) + i, d);
               send_g(d);
            end
         end else if (k <= 8) begin
            send_g(8'h04);
            exp_sync++;
         end else begin
            op = 8'($urandom);
            while (op >= 8'h01 && op <= 8'h04) op = 8'($urandom);
            send_g(op);
            exp_err = 1'b1;
         end
      end
      idle(4);
      check("rnd_q_empty", q_addr.size(), 0);
      check("rnd_sync_cnt", sync_seen, exp_sync);
      check("rnd_error", error, exp_err);
      check("rnd_busy", busy, 0);
      check("rnd_start_f", start_sample, exp_start);
      check("rnd_end_f", end_sample, exp_end);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
